// File: rtl/data_mem_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
// The state encoding and port ids are used by the top and by the bench.
package data_mem_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        READ_WAIT = 2'd2,
        ERR       = 2'd3
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// One requester port of the data memory arbiter: request handshake plus response pulse.
// The requester drives through the master modport; the arbiter uses the slave modport.
interface data_mem_arbiter_if
    import data_mem_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_arbiter_rr.sv
// Two-way round-robin arbiter: on contention the port that did not win last time is granted.
// last_grant resets to 1 so port 0 wins the first contention.
module rr_arbiter2 (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    logic last_grant_q;
    logic last_grant_d;

    for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
        assign gnt[gi] = req[gi] & (~req[1-gi] | (last_grant_q != 1'(gi)));
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (advance && (gnt != 2'b00)) begin
            last_grant_d = gnt[1];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
endmodule

// File: rtl/data_mem_arbiter.sv
// Shares a single-port, byte-addressed data memory between the CPU (port 0) and DMA (port 1).
// One transaction in flight; memory drive is registered and the 1-cycle read latency is absorbed.
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    data_mem_arbiter_if.slave        p0,
    data_mem_arbiter_if.slave        p1,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    input  logic [DATA_WIDTH-1:0]    mem_rd
);
    state_t                   state_q, state_d;
    logic                     owner_q, owner_d;
    logic                     we_q, we_d;
    logic                     mem_we_q, mem_we_d;
    logic [ADDRESS_WIDTH-1:0] mem_a_q, mem_a_d;
    logic [DATA_WIDTH-1:0]    mem_wd_q, mem_wd_d;

    logic [1:0]               gnt;
    logic                     in_idle;
    logic                     sel_we;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_wdata;
    logic                     rsp_fire;

    assign in_idle = (state_q == IDLE);

    rr_arbiter2 u_arb (
        .CLK     (CLK),
        .RST     (RST),
        .req     ({p1.req_valid, p0.req_valid}),
        .advance (in_idle),
        .gnt     (gnt)
    );

    assign sel_we    = gnt[1] ? p1.req_we    : p0.req_we;
    assign sel_addr  = gnt[1] ? p1.req_addr  : p0.req_addr;
    assign sel_wdata = gnt[1] ? p1.req_wdata : p0.req_wdata;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        mem_we_d = 1'b0;
        mem_a_d  = mem_a_q;
        mem_wd_d = mem_wd_q;
        case (state_q)
            IDLE: begin
                if (gnt != 2'b00) begin
                    owner_d = gnt[1];
                    we_d    = sel_we;
                    // Misaligned requests never reach the memory pins.
                    if (is_word_aligned(sel_addr[1:0])) begin
                        state_d  = ISSUE;
                        mem_we_d = sel_we;
                        mem_a_d  = sel_addr;
                        mem_wd_d = sel_wdata;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            ISSUE:     state_d = we_q ? IDLE : READ_WAIT;
            READ_WAIT: state_d = IDLE;
            ERR:       state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            owner_q  <= PORT_CPU;
            we_q     <= 1'b0;
            mem_we_q <= 1'b0;
            mem_a_q  <= '0;
            mem_wd_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            mem_we_q <= mem_we_d;
            mem_a_q  <= mem_a_d;
            mem_wd_q <= mem_wd_d;
        end
    end

    assign mem_we = mem_we_q;
    assign mem_a  = mem_a_q;
    assign mem_wd = mem_wd_q;

    // Writes respond in ISSUE; reads wait one more cycle for mem_rd.
    assign rsp_fire = ((state_q == ISSUE) && we_q) || (state_q == READ_WAIT) || (state_q == ERR);

    assign p0.req_ready = in_idle & gnt[0];
    assign p1.req_ready = in_idle & gnt[1];

    assign p0.rsp_valid = rsp_fire && (owner_q == PORT_CPU);
    assign p1.rsp_valid = rsp_fire && (owner_q == PORT_DMA);
    assign p0.rsp_err   = (state_q == ERR) && (owner_q == PORT_CPU);
    assign p1.rsp_err   = (state_q == ERR) && (owner_q == PORT_DMA);
    assign p0.rsp_rdata = ((state_q == READ_WAIT) && (owner_q == PORT_CPU)) ? mem_rd : '0;
    assign p1.rsp_rdata = ((state_q == READ_WAIT) && (owner_q == PORT_DMA)) ? mem_rd : '0;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a byte-addressed synchronous-read memory model.
// Inputs change 1 ns after the rising edge; outputs are sampled 2 ns after it.
module tb_data_mem_arbiter;
    import data_mem_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        mem_we;
    logic [8:0]  mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [7:0]  mem_bytes [0:511];

    int checks = 0;
    int errors = 0;
    int collisions = 0;
    int max_a = 0;

    data_mem_arbiter_if p0_if ();
    data_mem_arbiter_if p1_if ();

    data_mem_arbiter #(.ADDRESS_WIDTH(9), .DATA_WIDTH(32)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .p0     (p0_if),
        .p1     (p1_if),
        .mem_we (mem_we),
        .mem_a  (mem_a),
        .mem_wd (mem_wd),
        .mem_rd (mem_rd)
    );

    always #5 CLK = ~CLK;

    // Little-endian memory, one-cycle synchronous read.
    always @(posedge CLK) begin
        if (mem_we) begin
            mem_bytes[int'(mem_a)]     <= mem_wd[7:0];
            mem_bytes[int'(mem_a) + 1] <= mem_wd[15:8];
            mem_bytes[int'(mem_a) + 2] <= mem_wd[23:16];
            mem_bytes[int'(mem_a) + 3] <= mem_wd[31:24];
        end
        mem_rd <= {mem_bytes[(int'(mem_a) + 3) % 512], mem_bytes[(int'(mem_a) + 2) % 512],
                   mem_bytes[(int'(mem_a) + 1) % 512], mem_bytes[int'(mem_a)]};
    end

    always @(negedge CLK) begin
        if (p0_if.rsp_valid && p1_if.rsp_valid) collisions++;
        if (int'(mem_a) > max_a) max_a = int'(mem_a);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int port, input logic v, input logic we,
                           input logic [8:0] addr, input logic [31:0] wd);
        if (port == 0) begin
            p0_if.req_valid = v; p0_if.req_we = we; p0_if.req_addr = addr; p0_if.req_wdata = wd;
        end else begin
            p1_if.req_valid = v; p1_if.req_we = we; p1_if.req_addr = addr; p1_if.req_wdata = wd;
        end
    endtask

    function automatic logic ready_of(input int port);
        return (port == 0) ? p0_if.req_ready : p1_if.req_ready;
    endfunction

    function automatic logic rspv_of(input int port);
        return (port == 0) ? p0_if.rsp_valid : p1_if.rsp_valid;
    endfunction

    function automatic logic [31:0] rdata_of(input int port);
        return (port == 0) ? p0_if.rsp_rdata : p1_if.rsp_rdata;
    endfunction

    function automatic logic err_of(input int port);
        return (port == 0) ? p0_if.rsp_err : p1_if.rsp_err;
    endfunction

    task automatic do_reset();
        set_req(0, 1'b0, 1'b0, 9'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 9'h0, 32'h0);
        RST = 1'b1;
        cyc();
        cyc();
        RST = 1'b0;
    endtask

    task automatic do_write(input int port, input logic [8:0] addr, input logic [31:0] wd);
        set_req(port, 1'b1, 1'b1, addr, wd);
        #1 chk("wr_ready", 32'(ready_of(port)), 32'd1);
        cyc();
        set_req(port, 1'b0, 1'b0, 9'h0, 32'h0);
        #1;
        chk("wr_mem_we", 32'(mem_we), 32'd1);
        chk("wr_mem_a", 32'(mem_a), 32'(addr));
        chk("wr_mem_wd", mem_wd, wd);
        chk("wr_rsp_valid", 32'(rspv_of(port)), 32'd1);
        chk("wr_rsp_err", 32'(err_of(port)), 32'd0);
        $display("txn write p%0d addr=%h data=%h", port, addr, wd);
        cyc();
    endtask

    task automatic do_read(input int port, input logic [8:0] addr, input logic [31:0] exp);
        set_req(port, 1'b1, 1'b0, addr, 32'h0);
        #1 chk("rd_ready", 32'(ready_of(port)), 32'd1);
        cyc();
        set_req(port, 1'b0, 1'b0, 9'h0, 32'h0);
        #1;
        chk("rd_issue_rsp", 32'(rspv_of(port)), 32'd0);
        chk("rd_mem_we", 32'(mem_we), 32'd0);
        chk("rd_mem_a", 32'(mem_a), 32'(addr));
        cyc();
        #1;
        chk("rd_rsp_valid", 32'(rspv_of(port)), 32'd1);
        chk("rd_rdata", rdata_of(port), exp);
        chk("rd_rsp_err", 32'(err_of(port)), 32'd0);
        $display("txn read p%0d addr=%h data=%h", port, addr, rdata_of(port));
        cyc();
    endtask

    initial begin
        int ngrant;
        int r0;
        int r1;

        for (int i = 0; i < 512; i++) mem_bytes[i] = 8'h00;
        {mem_bytes[35], mem_bytes[34], mem_bytes[33], mem_bytes[32]} = 32'h11223344;
        {mem_bytes[67], mem_bytes[66], mem_bytes[65], mem_bytes[64]} = 32'h55667788;

        // Reset state
        do_reset();
        #1;
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_a", 32'(mem_a), 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        chk("rst_p0_rsp", 32'(p0_if.rsp_valid), 32'd0);
        chk("rst_p1_rsp", 32'(p1_if.rsp_valid), 32'd0);
        cyc();

        // 1: write then read back the same word
        do_write(0, 9'h010, 32'hDEADBEEF);
        do_read(0, 9'h010, 32'hDEADBEEF);

        // 2: simultaneous reads from reset, p0 first
        do_reset();
        set_req(0, 1'b1, 1'b0, 9'h020, 32'h0);
        set_req(1, 1'b1, 1'b0, 9'h040, 32'h0);
        #1;
        chk("t2_p0_ready", 32'(p0_if.req_ready), 32'd1);
        chk("t2_p1_ready", 32'(p1_if.req_ready), 32'd0);
        cyc();
        set_req(0, 1'b0, 1'b0, 9'h0, 32'h0);
        #1 chk("t2_p1_busy", 32'(p1_if.req_ready), 32'd0);
        cyc();
        #1;
        chk("t2_p0_rsp", 32'(p0_if.rsp_valid), 32'd1);
        chk("t2_p0_data", p0_if.rsp_rdata, 32'h11223344);
        chk("t2_p1_norsp", 32'(p1_if.rsp_valid), 32'd0);
        $display("txn read p0 addr=020 data=%h", p0_if.rsp_rdata);
        cyc();
        #1 chk("t2_p1_ready", 32'(p1_if.req_ready), 32'd1);
        cyc();
        set_req(1, 1'b0, 1'b0, 9'h0, 32'h0);
        cyc();
        #1;
        chk("t2_p1_rsp", 32'(p1_if.rsp_valid), 32'd1);
        chk("t2_p1_data", p1_if.rsp_rdata, 32'h55667788);
        chk("t2_p0_norsp", 32'(p0_if.rsp_valid), 32'd0);
        $display("txn read p1 addr=040 data=%h", p1_if.rsp_rdata);
        cyc();

        // 3: sustained contention, 8 grants alternate starting with p0
        ngrant = 0; r0 = 0; r1 = 0;
        set_req(0, 1'b1, 1'b0, 9'h020, 32'h0);
        set_req(1, 1'b1, 1'b0, 9'h040, 32'h0);
        for (int c = 0; c < 40; c++) begin
            #1;
            if (p0_if.req_ready) begin
                chk("t3_order", 32'd0, 32'(ngrant % 2));
                $display("txn grant p0 #%0d", ngrant);
                ngrant++;
            end
            if (p1_if.req_ready) begin
                chk("t3_order", 32'd1, 32'(ngrant % 2));
                $display("txn grant p1 #%0d", ngrant);
                ngrant++;
            end
            if (p0_if.rsp_valid) begin
                r0++;
                chk("t3_p0_data", p0_if.rsp_rdata, 32'h11223344);
            end
            if (p1_if.rsp_valid) begin
                r1++;
                chk("t3_p1_data", p1_if.rsp_rdata, 32'h55667788);
            end
            cyc();
            if (ngrant >= 8) begin
                set_req(0, 1'b0, 1'b0, 9'h0, 32'h0);
                set_req(1, 1'b0, 1'b0, 9'h0, 32'h0);
            end
        end
        chk("t3_grants", 32'(ngrant), 32'd8);
        chk("t3_p0_rsps", 32'(r0), 32'd4);
        chk("t3_p1_rsps", 32'(r1), 32'd4);

        // 4: misaligned p1 read reports an error without touching memory
        set_req(1, 1'b1, 1'b0, 9'h013, 32'h0);
        #1 chk("t4_ready", 32'(p1_if.req_ready), 32'd1);
        cyc();
        set_req(1, 1'b0, 1'b0, 9'h0, 32'h0);
        #1;
        chk("t4_rsp", 32'(p1_if.rsp_valid), 32'd1);
        chk("t4_err", 32'(p1_if.rsp_err), 32'd1);
        chk("t4_rdata", p1_if.rsp_rdata, 32'd0);
        chk("t4_mem_we", 32'(mem_we), 32'd0);
        chk("t4_mem_a", 32'(mem_a), 32'h040);
        chk("t4_p0_norsp", 32'(p0_if.rsp_valid), 32'd0);
        $display("txn misaligned p1 addr=013 err=%0b", p1_if.rsp_err);
        cyc();
        #1 chk("t4_rsp_pulse", 32'(p1_if.rsp_valid), 32'd0);
        cyc();

        // 5: highest legal word round-trips
        do_write(0, 9'h1FC, 32'hCAFEF00D);
        do_read(0, 9'h1FC, 32'hCAFEF00D);
        chk("t5_max_a", 32'(max_a <= 32'h1FC), 32'd1);

        // 6: reset while a read is in flight; priority returns to p0
        set_req(0, 1'b1, 1'b0, 9'h020, 32'h0);
        #1 chk("t6_ready", 32'(p0_if.req_ready), 32'd1);
        cyc();
        set_req(0, 1'b0, 1'b0, 9'h0, 32'h0);
        RST = 1'b1;
        cyc();
        #1;
        chk("t6_p0_rsp", 32'(p0_if.rsp_valid), 32'd0);
        chk("t6_p1_rsp", 32'(p1_if.rsp_valid), 32'd0);
        chk("t6_mem_we", 32'(mem_we), 32'd0);
        chk("t6_mem_a", 32'(mem_a), 32'd0);
        chk("t6_p0_data", p0_if.rsp_rdata, 32'd0);
        RST = 1'b0;
        cyc();
        #1 chk("t6_idle_rsp", 32'(p0_if.rsp_valid), 32'd0);
        set_req(0, 1'b1, 1'b0, 9'h020, 32'h0);
        set_req(1, 1'b1, 1'b0, 9'h040, 32'h0);
        #1;
        chk("t6_p0_prio", 32'(p0_if.req_ready), 32'd1);
        chk("t6_p1_wait", 32'(p1_if.req_ready), 32'd0);
        cyc();
        set_req(0, 1'b0, 1'b0, 9'h0, 32'h0);
        cyc();
        #1 chk("t6_p0_data2", p0_if.rsp_rdata, 32'h11223344);
        cyc();
        #1 chk("t6_p1_ready", 32'(p1_if.req_ready), 32'd1);
        cyc();
        set_req(1, 1'b0, 1'b0, 9'h0, 32'h0);
        cyc();
        #1;
        chk("t6_p1_rsp2", 32'(p1_if.rsp_valid), 32'd1);
        chk("t6_p1_data", p1_if.rsp_rdata, 32'h55667788);
        $display("txn read p1 addr=040 after reset data=%h", p1_if.rsp_rdata);
        cyc();

        chk("rsp_collisions", 32'(collisions), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
